// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t       : control FSM state encoding (S_IDLE, S_CALC, S_DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_datapath.sv
// Datapath of the sequential divider: operand registers, one restoring
// division step per cycle, and the result registers.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   load                 : accepted start; latch operands, clear partial remainder
//   step                 : perform one restoring step this cycle
//   last                 : final step; load quotient/remainder from the step result
//   dividend, divisor    : operands, sampled on load
//   quotient, remainder  : registered result
//   dsr_zero             : latched divisor (magnitude) is zero
module seq_divider_datapath
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dsr_zero
);

  // The partial remainder is always smaller than the divisor, so WIDTH bits
  // hold it; the extra bit only exists in the shifted/trial values below.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] dvd_n;
  logic             qbit;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // |v|; the most negative value maps onto itself, which read as unsigned is
  // its correct magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction
`endif

  // The dividend register doubles as the quotient shift register: each step
  // shifts its MSB into the remainder and its LSB receives the quotient bit.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dsr};
    qbit    = ~trial[WIDTH];
    rem_n   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_n   = {dvd[WIDTH-2:0], qbit};
  end

  assign dsr_zero = (dsr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (load) begin
      rem <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvd   <= magnitude(dividend);
      dsr   <= magnitude(divisor);
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
`else
      dvd <= dividend;
      dsr <= divisor;
`endif
    end else if (step) begin
      rem <= rem_n;
      dvd <= dvd_n;
      if (last) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        quotient  <= apply_sign(dvd_n, neg_q);
        remainder <= apply_sign(rem_n, neg_r);
`else
        quotient  <= dvd_n;
        remainder <= rem_n;
`endif
      end
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Control (FSM, iteration counter, Go edge detect) lives here; arithmetic
// lives in seq_divider_datapath.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands).
// Ports:
//   Clock, Reset         : clock, synchronous active-high reset
//   Go                   : start request, rising edge starts a divide
//   Dividend, Divisor    : operands, sampled on the accepted start edge
//   Quotient, Remainder  : registered result
//   Busy                 : high for the WIDTH iteration cycles
//   ResultValid          : Quotient/Remainder hold a completed result
//   DivByZero            : with ResultValid, the latched Divisor was zero
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             ResultValid,
  output logic             DivByZero
);

  state_t           state;
  logic             go_q;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             load;
  logic             step;
  logic             last;
  logic             dsr_zero;

  // A held Go starts only one divide; Go_q clears on reset, so Go held
  // through reset starts on the first cycle after release.
  assign start = Go && !go_q;
  assign load  = start && (state != S_CALC);
  assign step  = (state == S_CALC);
  assign last  = step && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      go_q        <= 1'b0;
      cnt         <= '0;
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      DivByZero   <= 1'b0;
    end else begin
      go_q <= Go;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_CALC;
            cnt         <= '0;
            Busy        <= 1'b1;
            ResultValid <= 1'b0;
            DivByZero   <= 1'b0;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state       <= S_DONE;
            Busy        <= 1'b0;
            ResultValid <= 1'b1;
            DivByZero   <= dsr_zero;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  seq_divider_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (Clock),
    .rst      (Reset),
    .load     (load),
    .step     (step),
    .last     (last),
    .dividend (Dividend),
    .divisor  (Divisor),
    .quotient (Quotient),
    .remainder(Remainder),
    .dsr_zero (dsr_zero)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider at WIDTH=4.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Go;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         ResultValid;
  logic         DivByZero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Go         (Go),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .Quotient   (Quotient),
    .Remainder  (Remainder),
    .Busy       (Busy),
    .ResultValid(ResultValid),
    .DivByZero  (DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One Go pulse; checks latency (edges from start edge to ResultValid,
  // inclusive), Busy duration, and the result.
  task automatic run_div(input string tag, input logic [W-1:0] dd, input logic [W-1:0] ds,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int cycles;
    int busy_cnt;
    Dividend = dd;
    Divisor  = ds;
    Go       = 1'b1;
    tick();
    Go       = 1'b0;
    check({tag, "_valid_drop"}, ResultValid, 1'b0);
    cycles   = 1;
    busy_cnt = Busy ? 1 : 0;
    while (!ResultValid && cycles < 20) begin
      tick();
      cycles++;
      if (Busy) busy_cnt++;
    end
    check({tag, "_latency"}, cycles, 5);
    check({tag, "_busy"}, busy_cnt, 4);
    check({tag, "_q"}, Quotient, eq);
    check({tag, "_r"}, Remainder, er);
    check({tag, "_dbz"}, DivByZero, ez);
    tick();
  endtask

  initial begin
    int rises;
    logic prev;
    logic seen;

    Reset = 1'b1; Go = 1'b0; Dividend = '0; Divisor = '0;
    tick(); tick();
    check("rst_q", Quotient, 0);
    check("rst_r", Remainder, 0);
    check("rst_busy", Busy, 0);
    check("rst_valid", ResultValid, 0);
    check("rst_dbz", DivByZero, 0);
    Reset = 1'b0;
    tick();

    run_div("d7_3", 4'd7, 4'd3, 4'd2, 4'd1, 1'b0);
    run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    run_div("d3_9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0);
    run_div("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1);

    // Outputs hold in S_DONE while Go stays low.
    tick(); tick(); tick();
    check("hold_q", Quotient, 4'd15);
    check("hold_r", Remainder, 4'd9);
    check("hold_valid", ResultValid, 1'b1);
    check("hold_dbz", DivByZero, 1'b1);

    // Go held 20 cycles: one divide of 13/4; operand changes mid-divide ignored.
    Dividend = 4'd13; Divisor = 4'd4; Go = 1'b1;
    rises = 0; prev = ResultValid;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) begin
        Dividend = 4'd2;
        Divisor  = 4'd1;
      end
      if (ResultValid && !prev) rises++;
      prev = ResultValid;
    end
    Go = 1'b0;
    check("held_go_results", rises, 1);
    check("held_go_q", Quotient, 4'd3);
    check("held_go_r", Remainder, 4'd1);
    tick();

    // Reset during the second S_CALC cycle abandons the divide.
    Dividend = 4'd7; Divisor = 4'd3; Go = 1'b1;
    tick();
    Go = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_q", Quotient, 0);
    check("midrst_r", Remainder, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_valid", ResultValid, 0);
    check("midrst_dbz", DivByZero, 0);
    check("midrst_state", int'(dut.state), int'(S_IDLE));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ResultValid) seen = 1'b1;
    end
    check("midrst_no_result", seen, 1'b0);

    // Go held through reset starts on the first cycle after release.
    Dividend = 4'd6; Divisor = 4'd2; Go = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check("go_thru_rst_busy", Busy, 1'b1);
    tick(); tick(); tick(); tick();
    check("go_thru_rst_valid", ResultValid, 1'b1);
    check("go_thru_rst_q", Quotient, 4'd3);
    check("go_thru_rst_r", Remainder, 4'd0);
    Go = 1'b0;
    tick();

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m7_2", 4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0);
    run_div("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0);
`else
    run_div("d10_3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
    run_div("d8_15", 4'd8, 4'd15, 4'd0, 4'd8, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
